// File: rtl/motion_pkg.sv
// Shared state encoding, default sprite geometry and the clamped step helper
// used by motion_scheduler and its testbench.
package motion_pkg;

    localparam logic [1:0] ENC_GROUND = 2'd0;
    localparam logic [1:0] ENC_RISE   = 2'd1;
    localparam logic [1:0] ENC_HANG   = 2'd2;
    localparam logic [1:0] ENC_FALL   = 2'd3;

    typedef enum logic [1:0] {
        ST_GROUND = ENC_GROUND,
        ST_RISE   = ENC_RISE,
        ST_HANG   = ENC_HANG,
        ST_FALL   = ENC_FALL
    } motion_state_e;

    localparam int unsigned X_INIT_DEF      = 32'd320;
    localparam int unsigned FLOOR_Y_DEF     = 32'd440;
    localparam int unsigned STEP_DEF        = 32'd2;
    localparam int unsigned JUMP_HEIGHT_DEF = 32'd50;
    localparam int unsigned HANG_TICKS_DEF  = 32'd4;
    localparam int unsigned X_MIN_DEF       = 32'd0;
    localparam int unsigned X_MAX_DEF       = 32'd623;

    localparam logic [10:0] PLAT_X_MIN = 11'd400;
    localparam logic [10:0] PLAT_X_MAX = 11'd639;
    localparam logic [10:0] PLAT_Y     = 11'd160;

    // Move one step in 11-bit space, clamped to [lo, hi] before narrowing.
    function automatic logic [9:0] step_clamp(
        input logic [10:0] pos,
        input logic        dec,
        input logic [10:0] step,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [10:0] res;
        if (dec) begin
            res = (pos < lo + step) ? lo : pos - step;
        end else begin
            res = (pos + step > hi) ? hi : pos + step;
        end
        return res[9:0];
    endfunction

endpackage

// File: rtl/motion_scheduler_key_edge_latch.sv
// Registers a level key, detects its rising edge and holds a pending flag
// until it is consumed or cleared; a same-cycle edge is visible immediately.
module key_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    input  logic i_consume,
    input  logic i_clear,
    output logic o_pending
);

    logic r_key_d;
    logic r_pending;
    logic w_edge;

    assign w_edge    = i_key & ~r_key_d;
    assign o_pending = r_pending | w_edge;

    // Key history and pending flag; clear wins over a simultaneous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_d   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_key_d <= i_key;
            if (i_consume || i_clear) begin
                r_pending <= 1'b0;
            end else if (w_edge) begin
                r_pending <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

endmodule

// File: rtl/motion_scheduler.sv
// Frame-tick sprite movement controller: horizontal stepping, jump profile and
// landing. Define PLATFORM_COLLISION_EN to enable the wall platform and walk-off.
module motion_scheduler
    import motion_pkg::*;
#(
    parameter int unsigned X_INIT      = X_INIT_DEF,
    parameter int unsigned FLOOR_Y     = FLOOR_Y_DEF,
    parameter int unsigned STEP        = STEP_DEF,
    parameter int unsigned JUMP_HEIGHT = JUMP_HEIGHT_DEF,
    parameter int unsigned HANG_TICKS  = HANG_TICKS_DEF,
    parameter int unsigned X_MIN       = X_MIN_DEF,
    parameter int unsigned X_MAX       = X_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [1:0] state,
    output logic       landed
);

    localparam logic [9:0]  L_X_INIT  = 10'(X_INIT);
    localparam logic [9:0]  L_FLOOR10 = 10'(FLOOR_Y);
    localparam logic [10:0] L_FLOOR   = 11'(FLOOR_Y);
    localparam logic [10:0] L_STEP    = 11'(STEP);
    localparam logic [10:0] L_JH      = 11'(JUMP_HEIGHT);
    localparam logic [10:0] L_HANG    = 11'(HANG_TICKS);
    localparam logic [10:0] L_XMIN    = 11'(X_MIN);
    localparam logic [10:0] L_XMAX    = 11'(X_MAX);

    logic [9:0]    r_x;
    logic [9:0]    r_y;
    motion_state_e r_state;
    logic [10:0]   r_rise_cnt;
    logic [10:0]   r_hang_cnt;
    logic          r_landed;

    logic          w_jump_pend;
    logic          w_consume;
    logic          w_clear;
    logic [9:0]    w_x_next;
    logic [10:0]   w_y_ext;
    logic [10:0]   w_y_up;
    logic [10:0]   w_y_down;
    logic [10:0]   w_rise_next;
    logic [10:0]   w_hang_next;
    logic          w_rise_done;
    logic          w_hang_done;
    logic          w_floor_hit;
`ifdef PLATFORM_COLLISION_EN
    logic          w_x_on_plat;
    logic          w_walk_off;
    logic          w_plat_hit;
`endif

    // Jumps are only taken from GROUND; any airborne tick drops a pending press.
    assign w_consume = frame_tick && (r_state == ST_GROUND);
    assign w_clear   = frame_tick && (r_state != ST_GROUND);

    key_edge_latch u_jump_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key     (key_jump),
        .i_consume (w_consume),
        .i_clear   (w_clear),
        .o_pending (w_jump_pend)
    );

    assign w_y_ext     = {1'b0, r_y};
    assign w_y_up      = (w_y_ext < L_STEP) ? 11'd0 : w_y_ext - L_STEP;
    assign w_y_down    = w_y_ext + L_STEP;
    assign w_rise_next = r_rise_cnt + L_STEP;
    assign w_hang_next = r_hang_cnt + 11'd1;
    assign w_rise_done = (w_rise_next >= L_JH) || (w_y_ext <= L_STEP);
    assign w_hang_done = (w_hang_next >= L_HANG);
    assign w_floor_hit = (w_y_down >= L_FLOOR);

`ifdef PLATFORM_COLLISION_EN
    assign w_x_on_plat = ({1'b0, r_x} >= PLAT_X_MIN) && ({1'b0, r_x} <= PLAT_X_MAX);
    assign w_walk_off  = (w_y_ext != L_FLOOR) && !w_x_on_plat;
    assign w_plat_hit  = w_x_on_plat && (w_y_ext < PLAT_Y) && (w_y_down >= PLAT_Y);
`endif

    // Horizontal target for this tick; opposing keys cancel.
    always_comb begin
        w_x_next = r_x;
        if (key_left && !key_right) begin
            w_x_next = step_clamp({1'b0, r_x}, 1'b1, L_STEP, L_XMIN, L_XMAX);
        end else if (key_right && !key_left) begin
            w_x_next = step_clamp({1'b0, r_x}, 1'b0, L_STEP, L_XMIN, L_XMAX);
        end else begin
            w_x_next = r_x;
        end
    end

    // Frame-tick state machine: position, jump profile and landing pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= L_X_INIT;
            r_y        <= L_FLOOR10;
            r_state    <= ST_GROUND;
            r_rise_cnt <= 11'd0;
            r_hang_cnt <= 11'd0;
            r_landed   <= 1'b0;
        end else begin
            r_landed <= 1'b0;
            if (frame_tick) begin
                r_x <= w_x_next;
                case (r_state)
                    ST_GROUND: begin
                        if (w_jump_pend) begin
                            r_state    <= ST_RISE;
                            r_rise_cnt <= 11'd0;
`ifdef PLATFORM_COLLISION_EN
                        end else if (w_walk_off) begin
                            r_state <= ST_FALL;
`endif
                        end else begin
                            r_state <= ST_GROUND;
                        end
                    end
                    ST_RISE: begin
                        r_y        <= w_y_up[9:0];
                        r_rise_cnt <= w_rise_next;
                        if (w_rise_done) begin
                            r_state    <= ST_HANG;
                            r_hang_cnt <= 11'd0;
                        end
                    end
                    ST_HANG: begin
                        r_hang_cnt <= w_hang_next;
                        if (w_hang_done) begin
                            r_state <= ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        if (w_floor_hit) begin
                            r_y      <= L_FLOOR10;
                            r_state  <= ST_GROUND;
                            r_landed <= 1'b1;
`ifdef PLATFORM_COLLISION_EN
                        end else if (w_plat_hit) begin
                            r_y      <= PLAT_Y[9:0];
                            r_state  <= ST_GROUND;
                            r_landed <= 1'b1;
`endif
                        end else begin
                            r_y <= w_y_down[9:0];
                        end
                    end
                    default: begin
                        r_state <= ST_GROUND;
                    end
                endcase
            end
        end
    end

    assign x_pos  = r_x;
    assign y_pos  = r_y;
    assign state  = r_state;
    assign landed = r_landed;

endmodule
